// File: rtl/fetch_controller_if.sv
// fetch_controller_if: bus bundle between the fetch controller, the instruction memory and decode.
//   imem_addr / imem_data              - combinational instruction memory read port
//   out_valid / out_ready              - valid/ready handshake towards decode
//   out_instr / out_pc                 - instruction and its fetch address
//   redirect_valid / redirect_pc       - branch/jump redirect from the back end
// Modports: master = fetch controller side, slave = memory/decode side.
interface fetch_controller_if #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned WORD_LENGTH = 32
);
    localparam int unsigned AW = $clog2(WIDTH);

    logic [AW-1:0]          imem_addr;
    logic [WORD_LENGTH-1:0] imem_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [WORD_LENGTH-1:0] out_instr;
    logic [AW-1:0]          out_pc;
    logic                   redirect_valid;
    logic [AW-1:0]          redirect_pc;

    modport master (
        output imem_addr,
        input  imem_data,
        output out_valid,
        input  out_ready,
        output out_instr,
        output out_pc,
        input  redirect_valid,
        input  redirect_pc
    );

    modport slave (
        input  imem_addr,
        output imem_data,
        input  out_valid,
        output out_ready,
        input  out_instr,
        input  out_pc,
        output redirect_valid,
        output redirect_pc
    );
endinterface

// File: rtl/fetch_controller.sv
// fetch_controller: sequences a combinational instruction memory for the front end.
// Holds the pc, reads imem at pc, registers the word and presents it to decode over a
// valid/ready handshake. Handles start, redirects, back-pressure stalls and halt detection.
//
// Ports:
//   clk, rst_n        - clock, asynchronous active-low reset
//   start, start_pc   - one-cycle start pulse and first fetch address (IDLE/HALT only)
//   bus (master)      - imem read port, decode handshake, redirect input
//   busy              - state is FETCH or STALL
//   halted            - state is HALT
//   fetch_err         - fetch ran off the end of memory (sticky until start or reset)
//
// Optional feature: define FETCH_WRAP_EN to wrap pc from WIDTH-1 to 0 instead of halting
// with fetch_err.
module fetch_controller #(
    parameter int unsigned             WIDTH       = 32,
    parameter int unsigned             WORD_LENGTH = 32,
    parameter logic [WORD_LENGTH-1:0] HALT_WORD   = '1
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       start,
    input  logic [$clog2(WIDTH)-1:0]   start_pc,
    fetch_controller_if.master         bus,
    output logic                       busy,
    output logic                       halted,
    output logic                       fetch_err
);
    localparam int unsigned AW = $clog2(WIDTH);
    localparam logic [AW-1:0] LAST_PC = AW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StFetch, StStall, StHalt} state_e;

    state_e                 state_q;
    logic [AW-1:0]          pc_q;
    logic                   valid_q;
    logic [WORD_LENGTH-1:0] instr_q;
    logic [AW-1:0]          opc_q;
    logic                   err_q;
    logic                   accepting;

    // Output register is free, or decode takes its contents this cycle.
    assign accepting = !valid_q || bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            pc_q    <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            opc_q   <= '0;
            err_q   <= 1'b0;
        end else if (state_q != StIdle && bus.redirect_valid) begin
            // Redirect wins over everything: flush the presented word, no capture this cycle.
            valid_q <= 1'b0;
            pc_q    <= bus.redirect_pc;
            state_q <= StFetch;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (start) begin
                        pc_q    <= start_pc;
                        state_q <= StFetch;
                    end
                end
                StFetch: begin
                    if (accepting) begin
                        instr_q <= bus.imem_data;
                        opc_q   <= pc_q;
                        valid_q <= 1'b1;
                        if (bus.imem_data == HALT_WORD) begin
                            // Halt word is still presented; pc stays on it.
                            state_q <= StHalt;
                        end else if (pc_q == LAST_PC) begin
`ifdef FETCH_WRAP_EN
                            pc_q <= '0;
`else
                            state_q <= StHalt;
                            err_q   <= 1'b1;
`endif
                        end else begin
                            pc_q <= pc_q + 1'b1;
                        end
                    end else begin
                        state_q <= StStall;
                    end
                end
                StStall: begin
                    // Release costs one bubble: the word leaves now, next capture next cycle.
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                        state_q <= StFetch;
                    end
                end
                StHalt: begin
                    if (bus.out_ready) begin
                        valid_q <= 1'b0;
                    end
                    if (start) begin
                        pc_q    <= start_pc;
                        err_q   <= 1'b0;
                        state_q <= StFetch;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.imem_addr = pc_q;
    assign bus.out_valid = valid_q;
    assign bus.out_instr = instr_q;
    assign bus.out_pc    = opc_q;
    assign busy          = (state_q == StFetch) || (state_q == StStall);
    assign halted        = (state_q == StHalt);
    assign fetch_err     = err_q;
endmodule

// File: tb/tb_fetch_controller.sv
// tb_fetch_controller: self-checking bench for fetch_controller.
// Directed scenarios plus a randomized run checked against an in-order fetch stream model.
module tb_fetch_controller;
    localparam int unsigned WIDTH = 32;
    localparam int unsigned WL    = 32;
    localparam int unsigned AW    = $clog2(WIDTH);
    localparam logic [WL-1:0] HALT = '1;
    localparam logic [AW-1:0] LAST = AW'(WIDTH - 1);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [AW-1:0] start_pc;
    logic          busy;
    logic          halted;
    logic          fetch_err;
    logic [WL-1:0] mem [WIDTH];
    int            errors = 0;
    int            checks = 0;

    fetch_controller_if #(.WIDTH(WIDTH), .WORD_LENGTH(WL)) bus ();

    fetch_controller #(
        .WIDTH      (WIDTH),
        .WORD_LENGTH(WL),
        .HALT_WORD  (HALT)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .start_pc (start_pc),
        .bus      (bus),
        .busy     (busy),
        .halted   (halted),
        .fetch_err(fetch_err)
    );

    always #5 clk = ~clk;

    assign bus.imem_data = mem[bus.imem_addr];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic step();
        @(negedge clk);
    endtask

    // Random memory contents, never the halt word.
    task automatic fill_mem();
        for (int i = 0; i < int'(WIDTH); i++) mem[i] = $urandom() & 32'h7fff_ffff;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        start_pc = '0;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        start = 1'b0;
        start_pc = '0;
        bus.out_ready = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc = '0;
        rst_n = 1'b1;
        #1;
        rst_n = 1'b0;
        step();
        checks++;
        if ({bus.out_valid, busy, halted, fetch_err} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_flags got=%b exp=0000", {bus.out_valid, busy, halted, fetch_err});
        end
        checks++;
        if ({bus.out_pc, bus.imem_addr, bus.out_instr} !== {AW'(0), AW'(0), WL'(0)}) begin
            errors++;
            $display("FAIL reset_regs got=%h exp=0", {bus.out_pc, bus.imem_addr, bus.out_instr});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_sequence();
        logic [WL-1:0] exp_w [4];
        exp_w = '{32'h11, 32'h22, 32'h33, HALT};
        fill_mem();
        for (int i = 0; i < 4; i++) mem[i] = exp_w[i];
        do_reset();
        start = 1'b1;
        start_pc = '0;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if ({busy, bus.out_valid, bus.imem_addr} !== {1'b1, 1'b0, AW'(0)}) begin
            errors++;
            $display("FAIL seq_start got=%h exp=%h", {busy, bus.out_valid, bus.imem_addr},
                     {1'b1, 1'b0, AW'(0)});
        end
        for (int k = 0; k < 4; k++) begin
            step();
            checks++;
            if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, AW'(k), exp_w[k]}) begin
                errors++;
                $display("FAIL seq_word%0d got=%h exp=%h", k,
                         {bus.out_valid, bus.out_pc, bus.out_instr}, {1'b1, AW'(k), exp_w[k]});
            end
        end
        checks++;
        if ({halted, busy} !== 2'b10) begin
            errors++;
            $display("FAIL seq_halted got=%b exp=10", {halted, busy});
        end
        step();
        checks++;
        if ({bus.out_valid, halted} !== 2'b01) begin
            errors++;
            $display("FAIL seq_drain got=%b exp=01", {bus.out_valid, halted});
        end
    endtask

    task automatic test_stall();
        fill_mem();
        do_reset();
        start = 1'b1;
        start_pc = AW'(8);
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        bus.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            step();
            checks++;
            if ({bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_addr, busy} !==
                {1'b1, AW'(8), mem[8], AW'(9), 1'b1}) begin
                errors++;
                $display("FAIL stall_hold%0d got=%h exp=%h", c,
                         {bus.out_valid, bus.out_pc, bus.out_instr, bus.imem_addr, busy},
                         {1'b1, AW'(8), mem[8], AW'(9), 1'b1});
            end
        end
        bus.out_ready = 1'b1;
        step();
        checks++;
        if (bus.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_bubble got=%b exp=0", bus.out_valid);
        end
        step();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, AW'(9), mem[9]}) begin
            errors++;
            $display("FAIL stall_next got=%h exp=%h", {bus.out_valid, bus.out_pc, bus.out_instr},
                     {1'b1, AW'(9), mem[9]});
        end
    endtask

    task automatic test_redirect();
        fill_mem();
        do_reset();
        start = 1'b1;
        start_pc = AW'(3);
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        step();
        checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, AW'(5)}) begin
            errors++;
            $display("FAIL redir_pre got=%h exp=%h", {bus.out_valid, bus.out_pc}, {1'b1, AW'(5)});
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = AW'(20);
        step();
        bus.redirect_valid = 1'b0;
        checks++;
        if ({bus.out_valid, bus.imem_addr} !== {1'b0, AW'(20)}) begin
            errors++;
            $display("FAIL redir_flush got=%h exp=%h", {bus.out_valid, bus.imem_addr},
                     {1'b0, AW'(20)});
        end
        step();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, AW'(20), mem[20]}) begin
            errors++;
            $display("FAIL redir_target got=%h exp=%h", {bus.out_valid, bus.out_pc, bus.out_instr},
                     {1'b1, AW'(20), mem[20]});
        end
        mem[21] = HALT;
        step();
        checks++;
        if ({halted, bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, 1'b1, AW'(21), HALT}) begin
            errors++;
            $display("FAIL redir_halt got=%h exp=%h", {halted, bus.out_valid, bus.out_pc,
                     bus.out_instr}, {1'b1, 1'b1, AW'(21), HALT});
        end
        bus.redirect_valid = 1'b1;
        bus.redirect_pc = AW'(7);
        step();
        bus.redirect_valid = 1'b0;
        checks++;
        if ({bus.out_valid, halted, busy, bus.imem_addr} !== {1'b0, 1'b0, 1'b1, AW'(7)}) begin
            errors++;
            $display("FAIL redir_resume got=%h exp=%h", {bus.out_valid, halted, busy, bus.imem_addr},
                     {1'b0, 1'b0, 1'b1, AW'(7)});
        end
        step();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, AW'(7), mem[7]}) begin
            errors++;
            $display("FAIL redir_resume_word got=%h exp=%h",
                     {bus.out_valid, bus.out_pc, bus.out_instr}, {1'b1, AW'(7), mem[7]});
        end
    endtask

    task automatic test_end_of_memory();
        fill_mem();
        do_reset();
        start = 1'b1;
        start_pc = AW'(WIDTH - 2);
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        checks++;
        if ({bus.out_valid, bus.out_pc} !== {1'b1, AW'(WIDTH - 2)}) begin
            errors++;
            $display("FAIL eom_pc30 got=%h exp=%h", {bus.out_valid, bus.out_pc},
                     {1'b1, AW'(WIDTH - 2)});
        end
        step();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, LAST, mem[WIDTH-1]}) begin
            errors++;
            $display("FAIL eom_pc31 got=%h exp=%h", {bus.out_valid, bus.out_pc, bus.out_instr},
                     {1'b1, LAST, mem[WIDTH-1]});
        end
`ifdef FETCH_WRAP_EN
        for (int k = 0; k < 2; k++) begin
            step();
            checks++;
            if ({bus.out_valid, bus.out_pc, bus.out_instr, fetch_err} !==
                {1'b1, AW'(k), mem[k], 1'b0}) begin
                errors++;
                $display("FAIL eom_wrap%0d got=%h exp=%h", k,
                         {bus.out_valid, bus.out_pc, bus.out_instr, fetch_err},
                         {1'b1, AW'(k), mem[k], 1'b0});
            end
        end
`else
        checks++;
        if ({halted, fetch_err, busy} !== 3'b110) begin
            errors++;
            $display("FAIL eom_err got=%b exp=110", {halted, fetch_err, busy});
        end
        step();
        checks++;
        if ({bus.out_valid, halted, fetch_err} !== 3'b011) begin
            errors++;
            $display("FAIL eom_sticky got=%b exp=011", {bus.out_valid, halted, fetch_err});
        end
        start = 1'b1;
        start_pc = '0;
        step();
        start = 1'b0;
        checks++;
        if ({fetch_err, busy, halted, bus.imem_addr} !== {1'b0, 1'b1, 1'b0, AW'(0)}) begin
            errors++;
            $display("FAIL eom_restart got=%h exp=%h", {fetch_err, busy, halted, bus.imem_addr},
                     {1'b0, 1'b1, 1'b0, AW'(0)});
        end
        step();
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, AW'(0), mem[0]}) begin
            errors++;
            $display("FAIL eom_restart_word got=%h exp=%h",
                     {bus.out_valid, bus.out_pc, bus.out_instr}, {1'b1, AW'(0), mem[0]});
        end
`endif
    endtask

    task automatic test_async_reset();
        fill_mem();
        do_reset();
        start = 1'b1;
        start_pc = '0;
        bus.out_ready = 1'b1;
        step();
        start = 1'b0;
        step();
        bus.out_ready = 1'b0;
        step();
        step();
        start = 1'b1;
        start_pc = AW'(12);
        step();
        start = 1'b0;
        checks++;
        if ({bus.out_valid, bus.out_pc, bus.out_instr, busy, bus.imem_addr} !==
            {1'b1, AW'(0), mem[0], 1'b1, AW'(1)}) begin
            errors++;
            $display("FAIL busy_start_ignored got=%h exp=%h",
                     {bus.out_valid, bus.out_pc, bus.out_instr, busy, bus.imem_addr},
                     {1'b1, AW'(0), mem[0], 1'b1, AW'(1)});
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({bus.out_valid, busy, halted, fetch_err, bus.out_pc, bus.imem_addr, bus.out_instr} !==
            {4'b0000, AW'(0), AW'(0), WL'(0)}) begin
            errors++;
            $display("FAIL async_reset got=%h exp=0", {bus.out_valid, busy, halted, fetch_err,
                     bus.out_pc, bus.imem_addr, bus.out_instr});
        end
        step();
        rst_n = 1'b1;
    endtask

    // Reference model: decode must see an in-order stream of (pc, mem[pc]) that restarts at each
    // redirect target; a held word never changes, a flushed cycle presents nothing.
    task automatic test_random();
        logic [AW-1:0] exp_pc;
        logic [AW-1:0] held_pc;
        logic [WL-1:0] held_instr;
        logic          flush_p;
        logic          hold_p;
        logic          redir;
        logic          v;
        logic          rdy;
        int            consumed;
        fill_mem();
        do_reset();
        start = 1'b1;
        start_pc = AW'($urandom_range(0, WIDTH - 1));
        bus.out_ready = 1'b1;
        exp_pc = start_pc;
        flush_p = 1'b0;
        hold_p = 1'b0;
        held_pc = '0;
        held_instr = '0;
        consumed = 0;
        step();
        start = 1'b0;
        for (int c = 0; c < 600; c++) begin
            step();
            if (flush_p) begin
                checks++;
                if (bus.out_valid !== 1'b0) begin
                    errors++;
                    $display("FAIL rnd_flush cyc=%0d got=%b exp=0", c, bus.out_valid);
                end
            end
            if (hold_p) begin
                checks++;
                if ({bus.out_valid, bus.out_pc, bus.out_instr} !== {1'b1, held_pc, held_instr}) begin
                    errors++;
                    $display("FAIL rnd_hold cyc=%0d got=%h exp=%h", c,
                             {bus.out_valid, bus.out_pc, bus.out_instr},
                             {1'b1, held_pc, held_instr});
                end
            end
            if (bus.out_valid === 1'b1) begin
                checks++;
                if ({bus.out_pc, bus.out_instr} !== {exp_pc, mem[exp_pc]}) begin
                    errors++;
                    $display("FAIL rnd_order cyc=%0d got=%h exp=%h", c,
                             {bus.out_pc, bus.out_instr}, {exp_pc, mem[exp_pc]});
                end
`ifndef FETCH_WRAP_EN
                if (exp_pc == LAST) begin
                    checks++;
                    if ({halted, fetch_err} !== 2'b11) begin
                        errors++;
                        $display("FAIL rnd_eom cyc=%0d got=%b exp=11", c, {halted, fetch_err});
                    end
                end
`endif
            end
`ifdef FETCH_WRAP_EN
            checks++;
            if (fetch_err !== 1'b0) begin
                errors++;
                $display("FAIL rnd_wrap_err cyc=%0d got=%b exp=0", c, fetch_err);
            end
`endif
            v = bus.out_valid;
            rdy = ($urandom() % 4) != 0;
            // Halted is only used to steer stimulus out of HALT.
            redir = halted || (($urandom() % 10) == 0);
            bus.out_ready = rdy;
            bus.redirect_valid = redir;
            bus.redirect_pc = AW'($urandom());
            flush_p = redir;
            hold_p = v && !rdy && !redir;
            held_pc = bus.out_pc;
            held_instr = bus.out_instr;
            if (v && rdy) consumed++;
            if (redir) exp_pc = bus.redirect_pc;
            else if (v && rdy) exp_pc = exp_pc + 1'b1;
        end
        bus.redirect_valid = 1'b0;
        checks++;
        if (consumed < 100) begin
            errors++;
            $display("FAIL rnd_progress got=%0d exp>=100", consumed);
        end
    endtask

    initial begin
        test_reset();
        test_sequence();
        test_stall();
        test_redirect();
        test_end_of_memory();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
